// File: rtl/bus_arbiter.sv
// Shared address/memory bus arbiter: CPU fetch, pipeline data cycles, one DMA.
// Optional burst-length cap guarded by BUS_ARBITER_BURST_LIMIT_EN.
module bus_arbiter #(
  parameter int BURST_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_request,
  input  logic       fetch_suppress,
  input  logic       dma_req,
  input  logic       dma_last,
  output logic       dma_grant,
  output logic       fetch_stall,
  output logic [1:0] addr_owner,
  output logic       conflict
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DMA,
    COOL
  } state_t;

  localparam logic [1:0] OWN_FETCH = 2'b00;
  localparam logic [1:0] OWN_DATA  = 2'b01;
  localparam logic [1:0] OWN_DMA   = 2'b10;
  localparam logic [1:0] OWN_NONE  = 2'b11;

  state_t state;
  state_t state_nxt;
  logic   limit_hit;
  logic   burst_end;
  logic   dma_entry;

  if (BURST_MAX < 2 || BURST_MAX > 256) begin : g_bad_burst_max
    $error("bus_arbiter: BURST_MAX must be 2..256");
  end

  assign dma_entry = (state != DMA) && (state_nxt == DMA);

`ifdef BUS_ARBITER_BURST_LIMIT_EN
  localparam int CW = $clog2(BURST_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);

  logic [CW-1:0] burst_cnt;

  assign limit_hit = (burst_cnt == CNT_MAX);

  // Saturating count of granted cycles in the current burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (dma_entry) begin
      burst_cnt <= '0;
    end else if (state == DMA && !limit_hit) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign burst_end = !dma_req || dma_last || limit_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (dma_req) begin
          state_nxt = bus_request ? PEND : DMA;
        end
      end
      PEND: begin
        if (!dma_req) begin
          state_nxt = IDLE;
        end else if (!bus_request) begin
          state_nxt = DMA;
        end
      end
      DMA: begin
        if (burst_end) begin
          state_nxt = COOL;
        end
      end
      COOL: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Fetch is frozen while a burst is pending, so it shows no owner
  always_comb begin
    addr_owner = OWN_FETCH;
    if (reset) begin
      addr_owner = OWN_NONE;
    end else if (state == DMA) begin
      addr_owner = OWN_DMA;
    end else if (bus_request) begin
      addr_owner = OWN_DATA;
    end else if (fetch_suppress || state == PEND) begin
      addr_owner = OWN_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_grant   <= 1'b0;
      fetch_stall <= 1'b0;
      conflict    <= 1'b0;
    end else begin
      dma_grant   <= (state_nxt == DMA);
      fetch_stall <= (state_nxt == DMA) || (state_nxt == PEND);
      conflict    <= conflict || ((state == DMA) && bus_request);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus
// randomized traffic against a cycle-level ownership model.
module tb_bus_arbiter;

  localparam int BM = 4;
`ifdef BUS_ARBITER_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bus_request = 1'b0;
  logic       fetch_suppress = 1'b0;
  logic       dma_req = 1'b0;
  logic       dma_last = 1'b0;
  logic       dma_grant;
  logic       fetch_stall;
  logic [1:0] addr_owner;
  logic       conflict;

  int checks = 0;
  int errors = 0;

  bit m_grant;
  bit m_pend;
  bit m_cool;
  bit m_conf;
  int m_len;

  always #5 clk = ~clk;

  bus_arbiter #(.BURST_MAX(BM)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_request   (bus_request),
    .fetch_suppress(fetch_suppress),
    .dma_req       (dma_req),
    .dma_last      (dma_last),
    .dma_grant     (dma_grant),
    .fetch_stall   (fetch_stall),
    .addr_owner    (addr_owner),
    .conflict      (conflict)
  );

  task automatic model_reset();
    m_grant = 0;
    m_pend  = 0;
    m_cool  = 0;
    m_conf  = 0;
    m_len   = 0;
  endtask

  // One clock edge of the ownership rules, using the inputs at the edge
  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_cool) begin
      m_cool = 0;
    end else if (m_grant) begin
      if (bus_request) m_conf = 1;
      m_len++;
      if (!dma_req || dma_last || (LIMIT && m_len >= BM)) begin
        m_grant = 0;
        m_cool  = 1;
      end
    end else if (m_pend) begin
      if (!dma_req) begin
        m_pend = 0;
      end else if (!bus_request) begin
        m_pend  = 0;
        m_grant = 1;
        m_len   = 0;
      end
    end else if (dma_req) begin
      if (bus_request) begin
        m_pend = 1;
      end else begin
        m_grant = 1;
        m_len   = 0;
      end
    end
  endtask

  function automatic logic [1:0] m_owner();
    if (reset) return 2'b11;
    if (m_grant) return 2'b10;
    if (bus_request) return 2'b01;
    if (fetch_suppress || m_pend) return 2'b11;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic br, input logic fs,
                        input logic dr, input logic dl);
    bus_request    = br;
    fetch_suppress = fs;
    dma_req        = dr;
    dma_last       = dl;
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 1);
    #2;
    checks++;
    if (dma_grant !== 1'b0) begin
      errors++;
      $display("FAIL rst_grant: got %b want 0", dma_grant);
    end
    checks++;
    if (fetch_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall: got %b want 0", fetch_stall);
    end
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL rst_conflict: got %b want 0", conflict);
    end
    checks++;
    if (addr_owner !== 2'b11) begin
      errors++;
      $display("FAIL rst_owner: got %b want 11", addr_owner);
    end
    set_in(0, 0, 0, 0);
    tick();
    #3;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle_fetch();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (addr_owner !== 2'b00 || dma_grant !== 1'b0 ||
          fetch_stall !== 1'b0 || conflict !== 1'b0) begin
        errors++;
        $display("FAIL idle_fetch[%0d]: got own=%b g=%b s=%b c=%b want 00 0 0 0",
                 i, addr_owner, dma_grant, fetch_stall, conflict);
      end
    end
  endtask

  task automatic test_simple_burst();
    set_in(0, 0, 1, 0);
    tick();
    checks++;
    if ({dma_grant, fetch_stall, addr_owner} !== 4'b1110) begin
      errors++;
      $display("FAIL burst_start: got g=%b s=%b own=%b want 1 1 10",
               dma_grant, fetch_stall, addr_owner);
    end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if (dma_grant !== 1'b1) begin
        errors++;
        $display("FAIL burst_hold[%0d]: got %b want 1", i, dma_grant);
      end
    end
    dma_last = 1'b1;
    tick();
    checks++;
    if ({dma_grant, fetch_stall, addr_owner} !== 4'b0000) begin
      errors++;
      $display("FAIL burst_cool: got g=%b s=%b own=%b want 0 0 00",
               dma_grant, fetch_stall, addr_owner);
    end
    dma_last = 1'b0;
    tick();
    checks++;
    if (dma_grant !== 1'b0) begin
      errors++;
      $display("FAIL cool_ignores_req: got %b want 0", dma_grant);
    end
    tick();
    checks++;
    if (dma_grant !== 1'b1) begin
      errors++;
      $display("FAIL regrant_m2: got %b want 1", dma_grant);
    end
    dma_req = 1'b0;
    tick();
    checks++;
    if (dma_grant !== 1'b0) begin
      errors++;
      $display("FAIL req_drop_release: got %b want 0", dma_grant);
    end
    tick();
  endtask

  task automatic test_pending();
    set_in(1, 1, 1, 0);
    #1;
    checks++;
    if (addr_owner !== 2'b01) begin
      errors++;
      $display("FAIL pend_all_high_own: got %b want 01", addr_owner);
    end
    tick();
    checks++;
    if ({dma_grant, fetch_stall, addr_owner} !== 4'b0101) begin
      errors++;
      $display("FAIL pend_e0: got g=%b s=%b own=%b want 0 1 01",
               dma_grant, fetch_stall, addr_owner);
    end
    tick();
    checks++;
    if ({dma_grant, fetch_stall} !== 2'b01) begin
      errors++;
      $display("FAIL pend_e1: got g=%b s=%b want 0 1", dma_grant, fetch_stall);
    end
    set_in(0, 0, 1, 0);
    #1;
    checks++;
    if (addr_owner !== 2'b11) begin
      errors++;
      $display("FAIL pend_fetch_own: got %b want 11", addr_owner);
    end
    tick();
    checks++;
    if ({dma_grant, addr_owner} !== 3'b110) begin
      errors++;
      $display("FAIL pend_grant: got g=%b own=%b want 1 10", dma_grant, addr_owner);
    end
    dma_req = 1'b0;
    tick();
    tick();
    set_in(1, 0, 1, 0);
    tick();
    dma_req = 1'b0;
    tick();
    checks++;
    if ({dma_grant, fetch_stall} !== 2'b00) begin
      errors++;
      $display("FAIL pend_withdraw: got g=%b s=%b want 0 0", dma_grant, fetch_stall);
    end
    set_in(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_burst_limit();
    logic exp;
    dma_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = LIMIT ? ((i % 6) < 4) : 1'b1;
      checks++;
      if (dma_grant !== exp) begin
        errors++;
        $display("FAIL limit_pattern[%0d]: got %b want %b", i, dma_grant, exp);
      end
    end
    dma_req = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({dma_grant, fetch_stall} !== 2'b00) begin
      errors++;
      $display("FAIL limit_settle: got g=%b s=%b want 0 0", dma_grant, fetch_stall);
    end
  endtask

  task automatic test_conflict();
    set_in(0, 0, 1, 0);
    tick();
    tick();
    bus_request = 1'b1;
    #1;
    checks++;
    if (addr_owner !== 2'b10) begin
      errors++;
      $display("FAIL conflict_own: got %b want 10", addr_owner);
    end
    tick();
    checks++;
    if ({conflict, dma_grant} !== 2'b11) begin
      errors++;
      $display("FAIL conflict_set: got c=%b g=%b want 1 1", conflict, dma_grant);
    end
    bus_request = 1'b0;
    tick();
    dma_req = 1'b0;
    tick();
    tick();
    checks++;
    if ({conflict, dma_grant} !== 2'b10) begin
      errors++;
      $display("FAIL conflict_sticky: got c=%b g=%b want 1 0", conflict, dma_grant);
    end
  endtask

  task automatic test_async_reset();
    set_in(0, 0, 1, 0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({dma_grant, fetch_stall, addr_owner, conflict} !== 5'b00110) begin
      errors++;
      $display("FAIL async_reset: got g=%b s=%b own=%b c=%b want 0 0 11 0",
               dma_grant, fetch_stall, addr_owner, conflict);
    end
    model_reset();
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if (dma_grant !== 1'b1) begin
      errors++;
      $display("FAIL reset_resample: got %b want 1", dma_grant);
    end
    dma_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [1:0] eo;
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 0) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
      end
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0);
      #1;
      eo = m_owner();
      checks++;
      if (addr_owner !== eo) begin
        errors++;
        $display("FAIL rand_owner[%0d]: got %b want %b", n, addr_owner, eo);
      end
      tick();
      checks++;
      if (dma_grant !== m_grant || fetch_stall !== (m_grant || m_pend) ||
          conflict !== m_conf) begin
        errors++;
        $display("FAIL rand_regs[%0d]: got g=%b s=%b c=%b want %b %b %b",
                 n, dma_grant, fetch_stall, conflict,
                 m_grant, m_grant || m_pend, m_conf);
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_fetch();
    test_simple_burst();
    test_pending();
    test_burst_limit();
    test_conflict();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbitrates the shared address/memory bus between CPU instruction fetch, pipeline data cycles and one external DMA requester. It sits beside `control`:
- takes stage2's bus request (`control_stage2[13]`) and stage1's fetch suppress (`control_stage1[15]`);
- drives a fetch-stall back into pipeline stages 0/1 while DMA owns the bus.

The CPU always wins the bus for data cycles. DMA gets whole bursts, with an optional burst-length limit that guarantees the CPU forward progress.

## Interface
- `BURST_MAX`, 16: maximum consecutive DMA-owned cycles, used only with `BUS_ARBITER_BURST_LIMIT_EN`; legal range 2..256.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bus_request`  in  1  stage2 data-cycle request; pipeline owns the bus this cycle.
- `fetch_suppress`  in  1  stage1 suppresses the next fetch.
- `dma_req`  in  1  DMA requests the bus; held high for the whole burst.
- `dma_last`  in  1  qualifies `dma_req`: the current granted cycle is the final one of the burst.
- `dma_grant`  out  1  DMA owns the bus (registered).
- `fetch_stall`  out  1  freeze stage0/stage1 and PC increment (registered).
- `addr_owner`  out  2  bus owner: 00 fetch, 01 pipeline data, 10 DMA, 11 none.
- `conflict`  out  1  sticky error: `bus_request` was seen while DMA owned the bus.

## Operation
The state machine has four states: IDLE, PEND, DMA, COOL. `addr_owner` is decoded combinationally from state and inputs. All other outputs are registered.

- **IDLE**
  - `addr_owner` = 01 if `bus_request`; else 11 if `fetch_suppress`; else 00.
  - `dma_req` && !`bus_request` -> DMA.
  - `dma_req` && `bus_request` -> PEND.
- **PEND**
  - `fetch_stall`=1; `addr_owner` as in IDLE (data cycles drain, fetch shows 11).
  - !`bus_request` -> DMA.
  - `dma_req` dropped -> IDLE (request withdrawn).
- **DMA**
  - `dma_grant`=1, `fetch_stall`=1, `addr_owner`=10.
  - Exit to COOL on any of: `dma_req`=0; `dma_req`&&`dma_last` sampled; burst counter reaching `BURST_MAX`-1 (limit build only).
- **COOL**
  - Exactly one cycle: `dma_grant`=0, `fetch_stall`=0, `addr_owner` as in IDLE.
  - `dma_req` is ignored, so at least one CPU bus cycle occurs between bursts.
  - -> IDLE.

Burst counter:
- Width is clog2(`BURST_MAX`).
- Clears on entry to DMA and increments each DMA cycle.
- Saturates; it never wraps.

`conflict`:
- Set on any edge where state=DMA and `bus_request`=1.
- Cleared only by `reset`.
- Arbitration is unaffected: DMA keeps the bus, and `addr_owner` stays 10.

## Timing
- Reset values: state IDLE, `dma_grant` 0, `fetch_stall` 0, `conflict` 0, counter 0.
- `addr_owner` is forced to 11 while `reset` is high.
- `reset` asserted mid-burst drops `dma_grant` and `fetch_stall` immediately, without waiting for a clock edge.
- Grant latency: `dma_req` sampled high at edge N with `bus_request` low gives `dma_grant`=1 after edge N. This is 1 cycle minimum.
- PEND: `fetch_stall` rises after the edge that samples `dma_req`. Grant follows the first edge at which `bus_request` is sampled low.
- Release: the exit condition sampled at edge M gives `dma_grant`=0 after edge M. COOL lasts for edges M..M+1. Re-grant is possible at the earliest after edge M+2.
- Simultaneous events:
  - `dma_req`, `bus_request` and `fetch_suppress` all high in IDLE -> `addr_owner`=01, next state PEND.
  - `dma_last` with burst-limit expiry in the same cycle -> single COOL; no double release.
- `dma_last` is ignored unless `dma_req`=1.

## Configuration
`BUS_ARBITER_BURST_LIMIT_EN`:
- **Defined:** the burst counter exists and DMA is forced to COOL after `BURST_MAX` granted cycles, even with `dma_req` still high. DMA then re-arbitrates from IDLE.
- **Undefined:**
  - No counter logic is built and `BURST_MAX` is unused.
  - DMA holds the bus until `dma_req` drops or `dma_last` is sampled.
  - The CPU can be starved indefinitely.

## Test plan
- **Idle fetch.** Release reset; hold `dma_req`, `bus_request`, `fetch_suppress` at 0 for 5 cycles -> `addr_owner`=00 every cycle, `dma_grant`=0, `fetch_stall`=0, `conflict`=0.
- **Simple burst.** `dma_req`=1 at edge 0 -> `dma_grant`=1, `fetch_stall`=1, `addr_owner`=10 after edge 0. `dma_last`=1 at edge 3 -> grant low after edge 3, one COOL cycle with `addr_owner`=00, IDLE after edge 4.
- **Pending.** `bus_request`=1 for edges 0-1 with `dma_req`=1 from edge 0 -> `fetch_stall`=1 after edge 0, `addr_owner`=01 for 2 cycles, `dma_grant`=1 only after edge 2.
- **Burst limit** (`BUS_ARBITER_BURST_LIMIT_EN`, `BURST_MAX`=4). `dma_req` held high 12 cycles -> grant pattern 1,1,1,1,0,(IDLE) then re-grant. Without the macro -> grant stays high for all 12 cycles.
- **Conflict.** Assert `bus_request` for 1 cycle mid-burst -> `conflict`=1 from that edge until reset; `addr_owner` stays 10.
- **Async reset.** Assert `reset` between clock edges mid-burst -> `dma_grant`, `fetch_stall` fall and `addr_owner`=11 with no clock edge. Deassert -> IDLE behaviour with `dma_req` re-sampled.
